// File: rtl/rate_sequence_ctrl_pkg.sv
// rate_sequence_ctrl_pkg: sequencer state encoding and rate-divider speed codes
package rate_sequence_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;
    localparam logic [1:0] SPD_FULL = 2'b00;
    localparam logic [1:0] SPD_1S   = 2'b01;
    localparam logic [1:0] SPD_2S   = 2'b10;
    localparam logic [1:0] SPD_4S   = 2'b11;
endpackage

// File: rtl/rate_seq_prog_mem.sv
// rate_seq_prog_mem: step program register file, sync write, async read, cleared on reset
module rate_seq_prog_mem #(
    parameter int NUM_STEPS = 4,
    parameter int TICK_W = 4,
    localparam int AW = $clog2(NUM_STEPS)
) (
    input  logic              ClockIn,
    input  logic              Reset,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [1:0]        wr_speed,
    input  logic [TICK_W-1:0] wr_ticks,
    input  logic [AW-1:0]     rd_addr,
    output logic [1:0]        rd_speed,
    output logic [TICK_W-1:0] rd_ticks
);
    logic [1:0]        speed_q [NUM_STEPS];
    logic [TICK_W-1:0] ticks_q [NUM_STEPS];
    // clear every entry on reset, otherwise store one entry per write cycle
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                speed_q[i] <= '0;
                ticks_q[i] <= '0;
            end
        end else if (we) begin
            speed_q[wr_addr] <= wr_speed;
            ticks_q[wr_addr] <= wr_ticks;
        end
    end
    assign rd_speed = speed_q[rd_addr];
    assign rd_ticks = ticks_q[rd_addr];
endmodule

// File: rtl/rate_sequence_ctrl.sv
// rate_sequence_ctrl: plays a {speed, tick-count} program against the rate divider
module rate_sequence_ctrl
    import rate_sequence_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = 4,
    parameter int TICK_W = 4,
    localparam int AW = $clog2(NUM_STEPS)
) (
    input  logic              ClockIn,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Loop,
    input  logic              ProgWrite,
    input  logic [AW-1:0]     ProgAddr,
    input  logic [1:0]        ProgSpeed,
    input  logic [TICK_W-1:0] ProgTicks,
    input  logic              TickIn,
    output logic [1:0]        Speed,
    output logic              DivReset,
    output logic [AW-1:0]     StepIndex,
    output logic              Busy,
    output logic              Done
);
    state_t            state;
    state_t            eos_state;
    logic [TICK_W-1:0] remaining;
    logic [TICK_W-1:0] entry_ticks;
    logic [1:0]        entry_speed;
    logic [AW-1:0]     eos_step;
    logic              pass_active;
    logic              last_step;
    logic              wrap;

    rate_seq_prog_mem #(.NUM_STEPS(NUM_STEPS), .TICK_W(TICK_W)) u_mem (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .we      (ProgWrite && !Busy),
        .wr_addr (ProgAddr),
        .wr_speed(ProgSpeed),
        .wr_ticks(ProgTicks),
        .rd_addr (StepIndex),
        .rd_speed(entry_speed),
        .rd_ticks(entry_ticks)
    );

    assign Busy = state inside {S_LOAD, S_RUN, S_PAUSED};
    assign Done = state == S_DONE;
    // Looping only restarts if some step in this pass actually ran, so an all-skip program terminates.
    assign last_step = StepIndex == AW'(NUM_STEPS - 1);
    assign wrap = last_step && Loop && pass_active;
    assign eos_state = (last_step && !wrap) ? S_DONE : S_LOAD;
    assign eos_step = last_step ? (wrap ? '0 : StepIndex) : StepIndex + 1'b1;

    // sequencer FSM: load entry, count divider ticks, advance/loop/finish, pause/resume
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state       <= S_IDLE;
            Speed       <= SPD_FULL;
            DivReset    <= 1'b0;
            StepIndex   <= '0;
            remaining   <= '0;
            pass_active <= 1'b0;
        end else begin
            DivReset <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start && !Stop) begin
                        state       <= S_LOAD;
                        StepIndex   <= '0;
                        pass_active <= 1'b0;
                    end
                end
                S_LOAD: begin
                    Speed     <= entry_speed;
                    remaining <= entry_ticks;
                    if (entry_ticks != '0) begin
                        DivReset    <= 1'b1;
                        pass_active <= 1'b1;
                        state       <= S_RUN;
                    end else begin
                        state     <= eos_state;
                        StepIndex <= eos_step;
                        if (wrap) pass_active <= 1'b0;
                    end
                end
                S_RUN: begin
                    // a tick coincident with the divider restart belongs to the old count
                    if (Stop) begin
                        state <= S_PAUSED;
                    end else if (TickIn && !DivReset && remaining != '0) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == TICK_W'(1)) begin
                            state     <= eos_state;
                            StepIndex <= eos_step;
                            if (wrap) pass_active <= 1'b0;
                        end
                    end
                end
                S_PAUSED: begin
                    if (Start && !Stop) state <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rate_sequence_ctrl.sv
// tb_rate_sequence_ctrl: directed tests with a behavioural program-player model
module tb_rate_sequence_ctrl;
    localparam int N = 4;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

    logic clk = 0, rst = 1, start = 0, stop = 0, loop = 0, pw = 0;
    logic tick_man = 0, tick_en = 0, tick_gen = 0;
    logic [1:0] pa = 0, ps = 0;
    logic [3:0] pt = 0;
    logic tick;
    logic [1:0] speed, step;
    logic div_reset, busy, done;
    int errors = 0, checks = 0, cyc_n = 0;
    bit chk_on = 0;
    int seen[$];

    assign tick = tick_man | (tick_en & tick_gen);
    always #5 clk = ~clk;

    rate_sequence_ctrl #(.NUM_STEPS(N), .TICK_W(4)) dut (
        .ClockIn(clk), .Reset(rst), .Start(start), .Stop(stop), .Loop(loop),
        .ProgWrite(pw), .ProgAddr(pa), .ProgSpeed(ps), .ProgTicks(pt), .TickIn(tick),
        .Speed(speed), .DivReset(div_reset), .StepIndex(step), .Busy(busy), .Done(done)
    );

    // free-running divider stand-in: one pulse every third cycle
    always @(negedge clk) begin
        cyc_n++;
        tick_gen = (cyc_n % 3 == 0);
    end

    // behavioural model of the program player
    int mode = M_IDLE, m_speed = 0, m_div = 0, m_step = 0, rem = 0, ran = 0, was_div = 0;
    int pspd[N], ptk[N];

    task automatic next_step();
        if (m_step < N - 1) begin
            m_step++;
            mode = M_LOAD;
        end else if (loop && ran != 0) begin
            m_step = 0;
            ran = 0;
            mode = M_LOAD;
        end else mode = M_DONE;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin pspd[i] = 0; ptk[i] = 0; end
            mode = M_IDLE; m_speed = 0; m_div = 0; m_step = 0; rem = 0; ran = 0;
        end else begin
            was_div = m_div;
            m_div = 0;
            if (pw && (mode == M_IDLE || mode == M_DONE)) begin
                pspd[pa] = ps;
                ptk[pa] = pt;
            end
            case (mode)
                M_IDLE, M_DONE: if (start && !stop) begin mode = M_LOAD; m_step = 0; ran = 0; end
                M_LOAD: begin
                    m_speed = pspd[m_step];
                    rem = ptk[m_step];
                    if (rem > 0) begin m_div = 1; ran = 1; mode = M_RUN; end
                    else next_step();
                end
                M_RUN: begin
                    if (stop) mode = M_PAUSED;
                    else if (tick && was_div == 0 && rem > 0) begin
                        rem--;
                        if (rem == 0) next_step();
                    end
                end
                M_PAUSED: if (start && !stop) mode = M_RUN;
                default: mode = M_IDLE;
            endcase
        end
    end

    // every-cycle comparison of all outputs against the model
    logic [6:0] act_v, exp_v;
    always @(negedge clk) begin
        if (chk_on) begin
            act_v = {speed, div_reset, step, busy, done};
            exp_v = {2'(m_speed), 1'(m_div), 2'(m_step),
                     1'(mode == M_LOAD || mode == M_RUN || mode == M_PAUSED), 1'(mode == M_DONE)};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model t=%0t {speed,div,step,busy,done} got %b want %b", $time, act_v, exp_v);
            end
        end
    end

    // record {step, speed} at every divider restart
    always @(negedge clk) if (div_reset === 1'b1) seen.push_back(int'(step) * 4 + int'(speed));

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic prog(int a, int s, int t);
        @(negedge clk);
        pw = 1; pa = 2'(a); ps = 2'(s); pt = 4'(t);
        @(negedge clk);
        pw = 0;
    endtask

    task automatic pulse_start(bit with_stop = 0);
        @(negedge clk);
        start = 1; stop = with_stop;
        @(negedge clk);
        start = 0; stop = 0;
    endtask

    // wait for Done (which=0) or DivReset (which=1), bounded
    task automatic wait_sig(string name, bit which, int bound);
        int n = 0;
        while (!(which ? div_reset : done) && n < bound) begin @(negedge clk); n++; end
        checks++;
        if (!(which ? div_reset : done)) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, got 0 want 1", name, bound);
        end
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk_on = 1;
        cyc(1);
        rst = 0;
        chk("rst_speed", speed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step", step, 0);
        chk("rst_div", div_reset, 0);
        pulse_start(1);
        cyc(2);
        chk("start_stop_idle_busy", busy, 0);

        // 1: four-step program, no loop
        prog(0, 1, 2); prog(1, 2, 1); prog(2, 3, 3); prog(3, 0, 1);
        tick_en = 1;
        seen.delete();
        pulse_start();
        cyc(1);
        chk("start_latency_div", div_reset, 1);
        wait_sig("t1_done", 0, 200);
        cyc(2);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_speed", speed, 0);
        chk("t1_pulses", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("t1_e0", seen[0], 1);
            chk("t1_e1", seen[1], 6);
            chk("t1_e2", seen[2], 11);
            chk("t1_e3", seen[3], 12);
        end

        // 2: skipped middle steps, loop back to step 0 once
        prog(0, 1, 1); prog(1, 0, 0); prog(2, 0, 0); prog(3, 2, 1);
        loop = 1;
        seen.delete();
        pulse_start();
        n = 0;
        while (seen.size() < 3 && n < 200) begin @(negedge clk); n++; end
        chk("t2_third_entry", seen.size(), 3);
        loop = 0;
        wait_sig("t2_done", 0, 200);
        cyc(2);
        chk("t2_pulses", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("t2_e1", seen[1], 14);
            chk("t2_e2", seen[2], 1);
        end
        chk("t2_step", step, 3);

        // 3: all-zero program with Loop set terminates without restarts
        for (int i = 0; i < N; i++) prog(i, 3, 0);
        loop = 1;
        seen.delete();
        pulse_start();
        n = 0;
        while (!done && n < 10) begin @(negedge clk); n++; end
        chk("t3_cycles", n, 4);
        chk("t3_done", done, 1);
        chk("t3_speed", speed, 3);
        cyc(2);
        chk("t3_pulses", seen.size(), 0);
        loop = 0;

        // 4: pause freezes the count, resume needs exactly the remaining ticks
        tick_en = 0;
        prog(0, 3, 3);
        seen.delete();
        pulse_start();
        wait_sig("t4_div", 1, 5);
        cyc(1);
        tick_man = 1; cyc(1); tick_man = 0;
        stop = 1; tick_en = 1;
        cyc(5);
        stop = 0; tick_en = 0;
        cyc(1);
        chk("t4_pause_step", step, 0);
        chk("t4_pause_busy", busy, 1);
        chk("t4_pause_speed", speed, 3);
        pulse_start();
        tick_man = 1; cyc(1); tick_man = 0;
        cyc(2);
        chk("t4_one_tick_busy", busy, 1);
        chk("t4_one_tick_step", step, 0);
        tick_man = 1; cyc(1); tick_man = 0;
        cyc(5);
        chk("t4_done", done, 1);
        chk("t4_pulses", seen.size(), 1);

        // 5: Start+Stop pauses; program write while busy is dropped
        tick_en = 1;
        prog(0, 2, 5);
        seen.delete();
        pulse_start();
        wait_sig("t5_div", 1, 5);
        cyc(2);
        pulse_start(1);
        cyc(1);
        chk("t5_paused_busy", busy, 1);
        chk("t5_paused_done", done, 0);
        prog(1, 3, 4);
        pulse_start();
        wait_sig("t5_done1", 0, 200);
        cyc(1);
        seen.delete();
        pulse_start();
        wait_sig("t5_done2", 0, 200);
        cyc(2);
        chk("t5_entry1_skipped", seen.size(), 1);
        chk("t5_speed", speed, 3);

        // 6: reset mid-run clears state and program
        prog(0, 1, 7);
        pulse_start();
        wait_sig("t6_div", 1, 5);
        cyc(3);
        rst = 1;
        cyc(1);
        rst = 0;
        chk("t6_speed", speed, 0);
        chk("t6_busy", busy, 0);
        chk("t6_step", step, 0);
        seen.delete();
        pulse_start();
        wait_sig("t6_done", 0, 10);
        cyc(2);
        chk("t6_pulses", seen.size(), 0);
        chk("t6_speed_after", speed, 0);
        tick_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
